// File: rtl/ce_freq_smooth.sv
// ce_freq_smooth: 3-tap [1 2 1]/4 smoothing across adjacent subcarriers.
// Frames arrive as sop..eop bursts. Each output is emitted once the next
// subcarrier is known. At the frame edges the missing neighbour is
// replaced by the edge sample. A one-cycle FLUSH emits the last subcarrier
// after eop.
module ce_freq_smooth #(
    parameter int W_DATA = 16,
    parameter int W_PTS  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic              sink_sop,
    input  logic              sink_eop,
    input  logic [W_DATA-1:0] sink_real,
    input  logic [W_DATA-1:0] sink_imag,
    input  logic [W_PTS-1:0]  fftpts_in,
    output logic              source_valid,
    input  logic              source_ready,
    output logic              source_sop,
    output logic              source_eop,
    output logic [W_DATA-1:0] source_real,
    output logic [W_DATA-1:0] source_imag,
    output logic [W_PTS-1:0]  fftpts_out,
    output logic              frame_err
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state_reg, state_next;
    logic              first_reg, first_next;
    logic [W_DATA-1:0] prev_reg [2];
    logic [W_DATA-1:0] prev_next [2];
    logic [W_DATA-1:0] cur_reg [2];
    logic [W_DATA-1:0] cur_next [2];
    logic [W_DATA-1:0] x_in [2];
    logic [W_DATA-1:0] run_y [2];
    logic [W_DATA-1:0] flush_y [2];

    logic              src_valid_reg, src_valid_next;
    logic              src_sop_reg, src_sop_next;
    logic              src_eop_reg, src_eop_next;
    logic [W_DATA-1:0] src_real_reg, src_real_next;
    logic [W_DATA-1:0] src_imag_reg, src_imag_next;
    logic [W_PTS-1:0]  fftpts_reg, fftpts_next;
    logic              frame_err_reg, frame_err_next;

    logic en;
    logic acc;

    // Handshake: the pipeline advances whenever the output register is free
    // or being drained; FLUSH takes one sink bubble to emit the last sample.
    assign en         = !src_valid_reg || source_ready;
    assign sink_ready = en && (state_reg != FLUSH);
    assign acc        = sink_valid && sink_ready;

    assign x_in[0] = sink_real;
    assign x_in[1] = sink_imag;

    // One filter lane per component (0 = real, 1 = imag).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic signed [W_DATA+1:0] p_ext, c_ext, n_ext;
            logic signed [W_DATA+1:0] run_sum, flush_sum;
            logic signed [W_DATA+1:0] run_shift, flush_shift;

            assign p_ext = {{2{prev_reg[gi][W_DATA-1]}}, prev_reg[gi]};
            assign c_ext = {{2{cur_reg[gi][W_DATA-1]}}, cur_reg[gi]};
            assign n_ext = {{2{x_in[gi][W_DATA-1]}}, x_in[gi]};

            // 18-bit sums cannot overflow; the rounded result always fits W_DATA.
            assign run_sum     = p_ext + (c_ext <<< 1) + n_ext + (W_DATA+2)'(2);
            assign flush_sum   = p_ext + (c_ext <<< 1) + c_ext + (W_DATA+2)'(2);
            assign run_shift   = run_sum >>> 2;
            assign flush_shift = flush_sum >>> 2;
            assign run_y[gi]   = run_shift[W_DATA-1:0];
            assign flush_y[gi] = flush_shift[W_DATA-1:0];
        end
    endgenerate

    // Next-state and output-register logic; nothing moves unless en is high.
    always_comb begin
        state_next     = state_reg;
        first_next     = first_reg;
        prev_next      = prev_reg;
        cur_next       = cur_reg;
        src_valid_next = src_valid_reg;
        src_sop_next   = src_sop_reg;
        src_eop_next   = src_eop_reg;
        src_real_next  = src_real_reg;
        src_imag_next  = src_imag_reg;
        fftpts_next    = fftpts_reg;
        frame_err_next = 1'b0;

        if (en) begin
            src_valid_next = 1'b0;
            case (state_reg)
                IDLE, RUN: begin
                    if (acc) begin
                        if (sink_sop) begin
                            // A sop while a frame is open drops the held sample.
                            if (state_reg == RUN) frame_err_next = 1'b1;
                            prev_next   = x_in;
                            cur_next    = x_in;
                            fftpts_next = fftpts_in;
                            if (sink_eop) begin
                                src_valid_next = 1'b1;
                                src_sop_next   = 1'b1;
                                src_eop_next   = 1'b1;
                                src_real_next  = sink_real;
                                src_imag_next  = sink_imag;
                                state_next     = IDLE;
                            end else begin
                                first_next = 1'b1;
                                state_next = RUN;
                            end
                        end else if (state_reg == IDLE) begin
                            frame_err_next = 1'b1;
                        end else begin
                            src_valid_next = 1'b1;
                            src_sop_next   = first_reg;
                            src_eop_next   = 1'b0;
                            src_real_next  = run_y[0];
                            src_imag_next  = run_y[1];
                            prev_next      = cur_reg;
                            cur_next       = x_in;
                            first_next     = 1'b0;
                            if (sink_eop) state_next = FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    src_valid_next = 1'b1;
                    src_sop_next   = 1'b0;
                    src_eop_next   = 1'b1;
                    src_real_next  = flush_y[0];
                    src_imag_next  = flush_y[1];
                    state_next     = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            first_reg     <= 1'b0;
            prev_reg      <= '{default: '0};
            cur_reg       <= '{default: '0};
            src_valid_reg <= 1'b0;
            src_sop_reg   <= 1'b0;
            src_eop_reg   <= 1'b0;
            src_real_reg  <= '0;
            src_imag_reg  <= '0;
            fftpts_reg    <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            first_reg     <= first_next;
            prev_reg      <= prev_next;
            cur_reg       <= cur_next;
            src_valid_reg <= src_valid_next;
            src_sop_reg   <= src_sop_next;
            src_eop_reg   <= src_eop_next;
            src_real_reg  <= src_real_next;
            src_imag_reg  <= src_imag_next;
            fftpts_reg    <= fftpts_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign source_valid = src_valid_reg;
    assign source_sop   = src_sop_reg;
    assign source_eop   = src_eop_reg;
    assign source_real  = src_real_reg;
    assign source_imag  = src_imag_reg;
    assign fftpts_out   = fftpts_reg;
    assign frame_err    = frame_err_reg;

endmodule
